comp_sub_pipe: RTL and testbench
================================

// Module: comp_sub_pipe
// PURPOSE
//  Pipelined complex floating-point subtractor: result = a - b, per component.
//  It is the inverse datapath of the complex adder. Each b component has its sign bit
//  flipped, and the two components then pass through two fpu_add instances (real, imag).
//  It sits in the DSP datapath between producers and consumers that use valid/ready
//  streams of packed {real, imag} words. Typical users are butterfly difference legs
//  and error terms.
// PARAMETERS
//  double  0  0: IEEE-754 single (size=32); 1: IEEE-754 double (size=64)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  in_valid   in   1       a/b hold a valid operand pair
//  in_ready   out  1       block accepts the pair this cycle
//  a          in   2*size  minuend: {real[2*size-1:size], imag[size-1:0]}
//  b          in   2*size  subtrahend, same packing as a
//  out_valid  out  1       result holds a valid difference
//  out_ready  in   1       consumer accepts result this cycle
//  result     out  2*size  {a.re-b.re, a.im-b.im}, same packing
//  busy       out  1       1 while any pipeline stage holds data
// BEHAVIOUR
//  - Reset: clock and reset are as decided: one clock, clk; rst_n is asynchronous
//    and active-low.
//    - While rst_n=0: out_valid=0, busy=0, in_ready=0, and all stage valid flags = 0.
//    - result data registers reset to 0.
//    - in_ready rises the first clk edge after rst_n deasserts.
//  - Handshakes:
//    - Input transfer occurs when in_valid & in_ready.
//    - Output transfer occurs when out_valid & out_ready.
//    - a and b are sampled only on an input transfer.
//  - Pipeline has two register stages:
//    - S1 registers a and b_neg, where b_neg = b with bits 2*size-1 and size-1 inverted.
//    - fpu_add is combinational between S1 and S2.
//    - S2 registers the fpu_add outputs and drives result.
//  - Latency: exactly 2 clk edges from input transfer to out_valid, with no backpressure.
//  - Throughput: 1 pair per cycle while out_ready=1.
//  - Advance rules:
//    - s2_en = !s2_valid | out_ready
//    - s1_en = !s1_valid | s2_en
//    - in_ready = s1_en, a combinational function of registered state and out_ready
//      only; never of in_valid.
//  - Backpressure:
//    - With out_ready=0, S2 holds result stable and S1 holds its content.
//    - in_ready deasserts once both stages are full.
//    - No data is dropped or duplicated.
//  - Simultaneous S2 drain and S1 refill in the same cycle is legal; a full pipe
//    stays full.
//  - out_valid = s2_valid; busy = s1_valid | s2_valid.
//  - result must not change while out_valid=1 and out_ready=0.
//  - Arithmetic:
//    - Rounding, NaN, Inf, and denormal handling are exactly those of fpu_add.
//    - The sign flip of a NaN b still yields NaN. Inf-Inf yields NaN per fpu_add.
//    - x - x yields +0 per fpu_add rounding.
//  - Reset mid-operation: all in-flight data is discarded immediately, with no
//    output transfer.
//  - No internal state beyond the two stages; ordering is strictly FIFO.
// TESTING
//  1. Single precision: a={0x40400000,0x3F800000} (3,1), b={0x3F800000,0x40000000} (1,2)
//     -> result={0x40000000,0xBF800000} (2,-1), out_valid exactly 2 cycles after accept.
//  2. Stream 8 pairs back-to-back with out_ready=1 -> 8 results in order on consecutive
//     cycles, in_ready constantly 1.
//  3. Hold out_ready=0 after 3 accepts -> in_ready=0 once 2 pairs are held, result stable.
//     Release -> all 3 results in order, none lost.
//  4. double=1: a={0x4008000000000000,0}, b={0x3FF0000000000000,0x3FF0000000000000}
//     -> result={0x4000000000000000,0xBFF0000000000000}.
//  5. Special values: b.re=0x7FC00000 (NaN) -> result.re NaN.
//     a.im=b.im=0x7F800000 (+Inf) -> result.im NaN. a=b -> +0 (0x00000000) both.
//  6. Assert rst_n=0 with both stages full -> out_valid=0 and busy=0 asynchronously,
//     and no stale result emitted after release.

Source files
------------

// File: rtl/comp_sub_pipe.sv
// rtl/comp_sub_pipe.sv - pipelined complex floating-point subtractor (a - b) built on fpu_add
module fpu_add #(
    parameter  int DOUBLE = 0,
    localparam int W      = (DOUBLE != 0) ? 64 : 32,
    localparam int EW     = (DOUBLE != 0) ? 11 : 8,
    localparam int MW     = W - EW - 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);
    // Significand carries hidden bit, fraction and guard/round/sticky.
    localparam int            SW   = MW + 4;
    localparam logic [EW-1:0] EMAX = '1;

    logic          w_sa, w_sb;
    logic [EW-1:0] w_ea, w_eb;
    logic [MW-1:0] w_ma, w_mb;
    logic          w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_big;

    assign {w_sa, w_ea, w_ma} = i_a;
    assign {w_sb, w_eb, w_mb} = i_b;
    assign w_nan_a = (w_ea == EMAX) && (w_ma != '0);
    assign w_nan_b = (w_eb == EMAX) && (w_mb != '0);
    assign w_inf_a = (w_ea == EMAX) && (w_ma == '0);
    assign w_inf_b = (w_eb == EMAX) && (w_mb == '0);
    assign w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};

    logic            w_sl, w_ss;
    logic [EW-1:0]   w_el_raw, w_es_raw, w_el, w_es;
    logic [MW-1:0]   w_ml, w_ms;
    logic [SW-1:0]   w_sig_l, w_sig_s, w_aligned;
    logic [EW-1:0]   w_dexp, w_shamt;
    logic [2*SW-1:0] w_wide;
    logic [SW:0]     w_sum;

    assign w_sl     = w_a_big ? w_sa : w_sb;
    assign w_ss     = w_a_big ? w_sb : w_sa;
    assign w_el_raw = w_a_big ? w_ea : w_eb;
    assign w_es_raw = w_a_big ? w_eb : w_ea;
    assign w_ml     = w_a_big ? w_ma : w_mb;
    assign w_ms     = w_a_big ? w_mb : w_ma;
    // Denormals share the scale of exponent 1 but have no hidden bit.
    assign w_el     = (w_el_raw == '0) ? EW'(1) : w_el_raw;
    assign w_es     = (w_es_raw == '0) ? EW'(1) : w_es_raw;
    assign w_sig_l  = {(w_el_raw != '0), w_ml, 3'b000};
    assign w_sig_s  = {(w_es_raw != '0), w_ms, 3'b000};

    assign w_dexp    = w_el - w_es;
    assign w_shamt   = (w_dexp > EW'(SW + 1)) ? EW'(SW + 1) : w_dexp;
    assign w_wide    = {w_sig_s, {SW{1'b0}}} >> w_shamt;
    assign w_aligned = w_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, (w_wide[SW-1:0] != '0)};
    assign w_sum     = (w_sl == w_ss) ? ({1'b0, w_sig_l} + {1'b0, w_aligned})
                                      : ({1'b0, w_sig_l} - {1'b0, w_aligned});

    logic [EW:0]      w_exp, w_efield;
    logic [SW-1:0]    w_norm;
    logic [EW+MW-1:0] w_packed;
    logic             w_rnd;
    int               w_lz, w_sh;

    always_comb begin
        w_exp  = {1'b0, w_el};
        w_norm = w_sum[SW-1:0];
        w_lz   = SW;
        w_sh   = 0;
        if (w_sum[SW]) begin
            w_norm = {w_sum[SW:2], (w_sum[1:0] != 2'b00)};
            w_exp  = w_exp + (EW+1)'(1);
        end else begin
            for (int i = 0; i < SW; i++) begin
                if (w_sum[i]) w_lz = SW - 1 - i;
            end
            // Never normalise below exponent 1: the remainder becomes a denormal.
            w_sh   = (w_lz > int'(w_exp) - 1) ? (int'(w_exp) - 1) : w_lz;
            w_norm = w_sum[SW-1:0] << w_sh;
            w_exp  = w_exp - (EW+1)'(w_sh);
        end
        w_efield = w_norm[SW-1] ? w_exp : '0;
        w_rnd    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        // Round carry ripples naturally into the exponent field (denormal->normal, ->Inf).
        w_packed = {w_efield[EW-1:0], w_norm[SW-2:3]} + {{(EW+MW-1){1'b0}}, w_rnd};
    end

    always_comb begin
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb)))
            o_sum = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
        else if (w_inf_a)
            o_sum = i_a;
        else if (w_inf_b)
            o_sum = i_b;
        else if (w_sum == '0)
            o_sum = {w_sa & w_sb, {(W-1){1'b0}}};
        else if (w_efield >= {1'b0, EMAX})
            o_sum = {w_sl, EMAX, {MW{1'b0}}};
        else
            o_sum = {w_sl, w_packed};
    end
endmodule

module comp_sub_pipe #(
    parameter  int double = 0,
    localparam int SIZE   = (double != 0) ? 64 : 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] a,
    input  logic [2*SIZE-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] result,
    output logic              busy
);
    localparam logic [2*SIZE-1:0] SIGN_MASK = {1'b1, {(SIZE-1){1'b0}}, 1'b1, {(SIZE-1){1'b0}}};

    logic              r_run, r_s1_valid, r_s2_valid;
    logic [2*SIZE-1:0] r_s1_a, r_s1_b, r_result;
    logic              w_s1_en, w_s2_en, w_in_fire;
    logic [SIZE-1:0]   w_re, w_im;

    assign w_s2_en   = !r_s2_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    // r_run keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_run && w_s1_en;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_a <= a;
                r_s1_b <= b ^ SIGN_MASK;
            end
        end
    end

    fpu_add #(.DOUBLE(double)) u_add_re (
        .i_a   (r_s1_a[2*SIZE-1:SIZE]),
        .i_b   (r_s1_b[2*SIZE-1:SIZE]),
        .o_sum (w_re)
    );

    fpu_add #(.DOUBLE(double)) u_add_im (
        .i_a   (r_s1_a[SIZE-1:0]),
        .i_b   (r_s1_b[SIZE-1:0]),
        .o_sum (w_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_result <= {w_re, w_im};
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign busy      = r_s1_valid || r_s2_valid;
endmodule

// File: tb/tb_comp_sub_pipe.sv
// tb/tb_comp_sub_pipe.sv - scoreboard bench for comp_sub_pipe, single and double instances
module tb_comp_sub_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic         s_in_ready, s_out_valid, s_busy;
    logic [63:0]  s_a = '0, s_b = '0, s_result;
    logic         d_in_valid = 1'b0, d_out_ready = 1'b1;
    logic         d_in_ready, d_out_valid, d_busy;
    logic [127:0] d_a = '0, d_b = '0, d_result;

    comp_sub_pipe #(.double(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .busy(s_busy));

    comp_sub_pipe #(.double(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .busy(d_busy));

    typedef struct {
        logic [127:0] res;
        bit           nan_re;
        bit           nan_im;
        bit           chk_lat;
        int           t_acc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_d[$];
    exp_t s_next, d_next;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rand_bp = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] v, input bit dbl);
        return dbl ? ((&v[62:52]) && (|v[51:0])) : ((&v[30:23]) && (|v[22:0]));
    endfunction

    task automatic check_comp(input string nm, input logic [63:0] act, input logic [63:0] exp,
                              input bit nan, input bit dbl);
        n_tests++;
        if (nan ? !is_nan(act, dbl) : (act !== exp)) begin
            n_fail++;
            if (nan) $display("FAIL %s: got %h, required a NaN", nm, act);
            else     $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic score(input string tag, input bit dbl, input logic [127:0] act, input exp_t e);
        logic [63:0] ar, ai, er, ei;
        if (dbl) begin
            ar = act[127:64];          ai = act[63:0];
            er = e.res[127:64];        ei = e.res[63:0];
        end else begin
            ar = {32'b0, act[63:32]};  ai = {32'b0, act[31:0]};
            er = {32'b0, e.res[63:32]}; ei = {32'b0, e.res[31:0]};
        end
        check_comp({tag, ".re"}, ar, er, e.nan_re, dbl);
        check_comp({tag, ".im"}, ai, ei, e.nan_im, dbl);
        if (e.chk_lat) check({tag, ".latency"}, 128'(cyc - e.t_acc), 128'd2);
    endtask

    // Monitor: records accepted pairs, pops and compares every output transfer.
    initial begin
        bit           s_hold, d_hold;
        logic [63:0]  s_prev;
        logic [127:0] d_prev;
        exp_t         e;
        s_hold = 1'b0; d_hold = 1'b0; s_prev = '0; d_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_hold = 1'b0;
                d_hold = 1'b0;
            end else begin
                if (s_in_valid && s_in_ready) begin
                    e = s_next; e.t_acc = cyc; q_s.push_back(e);
                end
                if (d_in_valid && d_in_ready) begin
                    e = d_next; e.t_acc = cyc; q_d.push_back(e);
                end
                if (s_out_valid) begin
                    if (s_hold) check("s.stable", 128'(s_result), 128'(s_prev));
                    if (s_out_ready) begin
                        if (q_s.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL s.unexpected: got result %h, required no output", s_result);
                        end else score("s", 1'b0, 128'(s_result), q_s.pop_front());
                    end
                end
                if (d_out_valid) begin
                    if (d_hold) check("d.stable", d_result, d_prev);
                    if (d_out_ready) begin
                        if (q_d.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL d.unexpected: got result %h, required no output", d_result);
                        end else score("d", 1'b1, d_result, q_d.pop_front());
                    end
                end
                s_hold = s_out_valid && !s_out_ready; s_prev = s_result;
                d_hold = d_out_valid && !d_out_ready; d_prev = d_result;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_s(input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                          input bit nre, input bit nim, input bit lat);
        bit acc;
        s_a = a; s_b = b;
        s_next.res = {64'b0, e}; s_next.nan_re = nre; s_next.nan_im = nim;
        s_next.chk_lat = lat; s_next.t_acc = 0;
        s_in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_tests++; n_fail++;
        $display("FAIL s.accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
    endtask

    task automatic send_d(input logic [127:0] a, input logic [127:0] b, input logic [127:0] e,
                          input bit nre, input bit nim, input bit lat);
        bit acc;
        d_a = a; d_b = b;
        d_next.res = e; d_next.nan_re = nre; d_next.nan_im = nim;
        d_next.chk_lat = lat; d_next.t_acc = 0;
        d_in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = d_in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_tests++; n_fail++;
        $display("FAIL d.accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
    endtask

    // Exact small integers only: format conversion from the host double encoding.
    function automatic logic [31:0] sp_of_int(input int v);
        logic [63:0] d;
        if (v == 0) return 32'h0;
        d = $realtobits(real'(v));
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [63:0] rnd_dp(input logic [10:0] ebase);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 15))
            0:       v[62:52] = 11'h7FF;
            1:       v[62:0]  = {11'h7FF, 52'b0};
            2:       v[62:52] = 11'h000;
            3:       v[62:0]  = '0;
            default: v[62:52] = ebase + 11'($urandom_range(0, 6)) - 11'd3;
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        #2;
        check("rst.s_out_valid", 128'(s_out_valid), 128'd0);
        check("rst.s_busy",      128'(s_busy),      128'd0);
        check("rst.s_in_ready",  128'(s_in_ready),  128'd0);
        check("rst.s_result",    128'(s_result),    128'd0);
        check("rst.d_in_ready",  128'(d_in_ready),  128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.in_ready_before_edge", 128'(s_in_ready), 128'd0);
        @(posedge clk);
        #1;
        check("rel.in_ready_after_edge", 128'(s_in_ready), 128'd1);

        // (3,1) - (1,2) = (2,-1)
        send_s({32'h40400000, 32'h3F800000}, {32'h3F800000, 32'h40000000},
               {32'h40000000, 32'hBF800000}, 1'b0, 1'b0, 1'b1);
        s_in_valid = 1'b0;
        tick(4);

        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            int ar, ai, br, bi;
            ar = int'($urandom_range(0, 2000)) - 1000; ai = int'($urandom_range(0, 2000)) - 1000;
            br = int'($urandom_range(0, 2000)) - 1000; bi = int'($urandom_range(0, 2000)) - 1000;
            send_s({sp_of_int(ar), sp_of_int(ai)}, {sp_of_int(br), sp_of_int(bi)},
                   {sp_of_int(ar - br), sp_of_int(ai - bi)}, 1'b0, 1'b0, 1'b1);
        end
        check("s.stream_cycles", 128'(cyc - c0), 128'd8);
        s_in_valid = 1'b0;
        tick(4);

        s_out_ready = 1'b0;
        send_s({sp_of_int(10), sp_of_int(-4)}, {sp_of_int(3), sp_of_int(5)},
               {sp_of_int(7), sp_of_int(-9)}, 1'b0, 1'b0, 1'b0);
        send_s({sp_of_int(100), sp_of_int(0)}, {sp_of_int(-28), sp_of_int(17)},
               {sp_of_int(128), sp_of_int(-17)}, 1'b0, 1'b0, 1'b0);
        check("bp.in_ready_full", 128'(s_in_ready), 128'd0);
        check("bp.busy_full",     128'(s_busy),     128'd1);
        fork
            send_s({sp_of_int(-6), sp_of_int(9)}, {sp_of_int(-6), sp_of_int(12)},
                   {sp_of_int(0), sp_of_int(-3)}, 1'b0, 1'b0, 1'b0);
            begin
                tick(3);
                check("bp.in_ready_held", 128'(s_in_ready), 128'd0);
                check("bp.out_valid_held", 128'(s_out_valid), 128'd1);
                s_out_ready = 1'b1;
            end
        join
        s_in_valid = 1'b0;
        tick(5);
        check("bp.drained", 128'(q_s.size()), 128'd0);

        // NaN operand, Inf-Inf, a=b, signed zeros, Inf-finite, denormals, overflow
        send_s({32'h3F800000, 32'h7F800000}, {32'h7FC00000, 32'h7F800000},
               64'h0, 1'b1, 1'b1, 1'b1);
        send_s({32'h40490FDB, 32'hC0000000}, {32'h40490FDB, 32'hC0000000},
               {32'h00000000, 32'h00000000}, 1'b0, 1'b0, 1'b1);
        send_s({32'h80000000, 32'h00000000}, {32'h00000000, 32'h80000000},
               {32'h80000000, 32'h00000000}, 1'b0, 1'b0, 1'b1);
        send_s({32'h7F800000, 32'h00000002}, {32'h3F800000, 32'h00000001},
               {32'h7F800000, 32'h00000001}, 1'b0, 1'b0, 1'b1);
        send_s({32'h7F7FFFFF, 32'h3FC00000}, {32'hFF7FFFFF, 32'h3F800000},
               {32'h7F800000, 32'h3F000000}, 1'b0, 1'b0, 1'b1);
        s_in_valid = 1'b0;
        tick(4);

        send_d({64'h4008000000000000, 64'h0}, {64'h3FF0000000000000, 64'h3FF0000000000000},
               {64'h4000000000000000, 64'hBFF0000000000000}, 1'b0, 1'b0, 1'b1);
        d_in_valid = 1'b0;
        tick(4);

        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    d_out_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                d_out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 160; i++) begin
                    logic [63:0] xr, xi, yr, yi, er, ei;
                    logic [10:0] eb;
                    case ($urandom_range(0, 5))
                        0:       eb = 11'd3;
                        1:       eb = 11'd2043;
                        default: eb = 11'($urandom_range(900, 1100));
                    endcase
                    xr = rnd_dp(eb); yr = ($urandom_range(0, 7) == 0) ? xr : rnd_dp(eb);
                    xi = rnd_dp(eb); yi = ($urandom_range(0, 7) == 0) ? xi : rnd_dp(eb);
                    er = $realtobits($bitstoreal(xr) - $bitstoreal(yr));
                    ei = $realtobits($bitstoreal(xi) - $bitstoreal(yi));
                    send_d({xr, xi}, {yr, yi}, {er, ei}, is_nan(er, 1'b1), is_nan(ei, 1'b1), 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        d_in_valid = 1'b0;
                        tick(1);
                    end
                end
                d_in_valid = 1'b0;
                rand_bp = 1'b0;
            end
        join
        for (int k = 0; k < 200 && q_d.size() != 0; k++) tick(1);
        check("d.drained", 128'(q_d.size()), 128'd0);

        // Reset with both stages full: everything in flight is discarded.
        s_out_ready = 1'b0;
        send_s({sp_of_int(5), sp_of_int(5)}, {sp_of_int(1), sp_of_int(1)},
               {sp_of_int(4), sp_of_int(4)}, 1'b0, 1'b0, 1'b0);
        send_s({sp_of_int(6), sp_of_int(6)}, {sp_of_int(1), sp_of_int(1)},
               {sp_of_int(5), sp_of_int(5)}, 1'b0, 1'b0, 1'b0);
        s_in_valid = 1'b0;
        check("mid.busy_before", 128'(s_busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        q_s.delete();
        check("mid.out_valid", 128'(s_out_valid), 128'd0);
        check("mid.busy",      128'(s_busy),      128'd0);
        check("mid.in_ready",  128'(s_in_ready),  128'd0);
        check("mid.result",    128'(s_result),    128'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        s_out_ready = 1'b1;
        tick(5);
        check("mid.no_stale", 128'(s_out_valid), 128'd0);
        send_s({sp_of_int(9), sp_of_int(-2)}, {sp_of_int(4), sp_of_int(-2)},
               {sp_of_int(5), sp_of_int(0)}, 1'b0, 1'b0, 1'b1);
        s_in_valid = 1'b0;
        tick(5);
        check("final.s_drained", 128'(q_s.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
